// File: rtl/seq_playback_arbiter_pkg.sv
// Shared constants, default sequence table and FSM states for the playback arbiter.
package seq_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = $clog2(DEPTH);

    localparam logic [DATA_W-1:0] DEF_TABLE [DEPTH] = '{
        8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
    };

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/seq_playback_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer flips to the other requester on every accept.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant,
    output logic       o_gid,
    output logic       o_accept
);

    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            if (i_valid == 2'b11) begin
                o_grant = r_ptr ? 2'b10 : 2'b01;
            end else begin
                o_grant = i_valid;
            end
        end
    end

    // A grant is only ever raised for a valid requester, so any grant is an accept.
    assign o_gid    = o_grant[1];
    assign o_accept = |o_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (o_accept) begin
            r_ptr <= ~o_gid;
        end
    end

endmodule

// File: rtl/seq_playback_arbiter.sv
// Plays bursts out of a programmable 8-entry byte table for two round-robin requesters.
module seq_playback_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int NREQ   = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_we,
    input  logic [$clog2(DEPTH)-1:0]         cfg_addr,
    input  logic [DATA_W-1:0]                cfg_wdata,
    output logic                             cfg_ready,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ*$clog2(DEPTH)-1:0]    req_start,
    input  logic [NREQ*$clog2(DEPTH)-1:0]    req_len_m1,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_id,
    output logic                             out_last,
    output logic                             busy
);

    import seq_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_table [DEPTH];
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_remain;
    logic [DATA_W-1:0]  r_data;
    logic               r_id;
    logic [1:0]         w_grant;
    logic               w_gid;
    logic               w_accept;
    logic               w_fire;
    logic               w_wr;
    logic               w_more;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_len;
    logic [IDX_W-1:0]   w_idx_inc;

    assign busy      = (r_state == PLAY);
    assign cfg_ready = ~busy;
    assign w_wr      = cfg_we & cfg_ready;
    assign w_fire    = busy & out_ready;
    assign w_more    = (r_remain != '0);
    assign w_idx_inc = r_idx + IDX_W'(1);

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_enable (~busy & ~reset),
        .i_valid  (req_valid),
        .o_grant  (w_grant),
        .o_gid    (w_gid),
        .o_accept (w_accept)
    );

    assign req_ready = w_grant;
    assign w_start   = req_start[w_gid*IDX_W +: IDX_W];
    assign w_len     = req_len_m1[w_gid*IDX_W +: IDX_W];

    assign out_valid = busy;
    assign out_last  = busy & ~w_more;
    assign out_data  = r_data;
    assign out_id    = r_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= DEF_TABLE[i];
            end
        end else if (w_wr) begin
            r_table[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = PLAY;
            PLAY:    if (w_fire && !w_more) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A same-edge config write to the start entry must be visible in the first beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_remain <= '0;
            r_data   <= '0;
            r_id     <= 1'b0;
        end else if (w_accept) begin
            r_idx    <= w_start;
            r_remain <= w_len;
            r_id     <= w_gid;
            r_data   <= (w_wr && (cfg_addr == w_start)) ? cfg_wdata : r_table[w_start];
        end else if (w_fire && w_more) begin
            r_idx    <= w_idx_inc;
            r_remain <= r_remain - IDX_W'(1);
            r_data   <= r_table[w_idx_inc];
        end
    end

endmodule

// File: tb/tb_seq_playback_arbiter.sv
// Randomized and directed bench for seq_playback_arbiter against a burst-queue reference model.
module tb_seq_playback_arbiter;

    logic       clk;
    logic       reset;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       cfg_ready;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [5:0] req_start;
    logic [5:0] req_len_m1;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_id;
    logic       out_last;
    logic       busy;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] m_tab [8];
    int         m_ptr;
    logic [9:0] m_q [$];
    logic [9:0] got [$];

    logic [7:0] exp1 [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
    logic [7:0] exp2 [4] = '{8'h0B, 8'h8D, 8'hAF, 8'hBC};

    seq_playback_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_ready  (cfg_ready),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_start  (req_start),
        .req_len_m1 (req_len_m1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_tab = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
        m_ptr = 0;
        m_q.delete();
    endtask

    // Called at a falling edge with inputs already driven; checks, advances the model, and
    // returns at the next falling edge.
    task automatic step();
        logic [1:0] g;
        int         gid;
        int         s;
        int         l;
        #1;
        g = 2'b00;
        if (m_q.size() == 0) begin
            if (req_valid == 2'b11) g = (m_ptr == 0) ? 2'b01 : 2'b10;
            else                    g = req_valid;
        end
        chk("req_ready", req_ready, g);
        chk("busy", busy, m_q.size() != 0);
        chk("cfg_ready", cfg_ready, m_q.size() == 0);
        chk("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("out_data", out_data, m_q[0][7:0]);
            chk("out_last", out_last, m_q[0][8]);
            chk("out_id", out_id, m_q[0][9]);
        end
        if (out_valid && out_ready) got.push_back({out_id, out_last, out_data});
        if (m_q.size() != 0) begin
            if (out_ready) void'(m_q.pop_front());
        end else begin
            if (cfg_we) m_tab[cfg_addr] = cfg_wdata;
            if (g != 2'b00) begin
                gid = g[1] ? 1 : 0;
                s   = (gid == 1) ? int'(req_start[5:3])  : int'(req_start[2:0]);
                l   = (gid == 1) ? int'(req_len_m1[5:3]) : int'(req_len_m1[2:0]);
                for (int b = 0; b <= l; b++) begin
                    m_q.push_back({gid[0], (b == l), m_tab[(s + b) % 8]});
                end
                m_ptr = 1 - gid;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        req_valid  = 2'b11;
        req_start  = '0;
        req_len_m1 = '0;
        out_ready  = 1'b1;
        m_reset();
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 2'b00;

        // default playback of the whole table
        got.delete();
        req_valid = 2'b01; req_start = {3'd0, 3'd0}; req_len_m1 = {3'd0, 3'd7};
        step();
        req_valid = 2'b00;
        repeat (9) step();
        chk("t1_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) begin
            chk("t1_data", got[i][7:0], exp1[i]);
            chk("t1_last", got[i][8], i == 7);
            chk("t1_id", got[i][9], 0);
        end

        // wrap-around with backpressure on beat 2
        got.delete();
        req_valid = 2'b10; req_start = {3'd6, 3'd0}; req_len_m1 = {3'd3, 3'd0};
        step();
        req_valid = 2'b00;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (4) step();
        chk("t2_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            chk("t2_data", got[i][7:0], exp2[i]);
            chk("t2_id", got[i][9], 1);
        end

        // both requesters hammering with single-beat bursts
        got.delete();
        req_valid = 2'b11; req_start = {3'd1, 3'd0}; req_len_m1 = '0;
        repeat (8) step();
        chk("t3_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("t3_id", got[i][9], i % 2);
        got.delete();
        req_valid = 2'b10;
        repeat (6) step();
        req_valid = 2'b00;
        step();
        chk("t3b_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("t3b_id", got[i][9], 1);

        // config write in idle, then playback
        got.delete();
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 8'h55;
        step();
        cfg_we = 1'b0;
        req_valid = 2'b01; req_start = {3'd0, 3'd1}; req_len_m1 = {3'd0, 3'd1};
        step();
        req_valid = 2'b00;
        repeat (3) step();
        chk("t4_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t4_d0", got[0][7:0], 8'hBC);
            chk("t4_d1", got[1][7:0], 8'h55);
        end

        // write while busy is dropped
        req_valid = 2'b01; req_start = {3'd0, 3'd2}; req_len_m1 = {3'd0, 3'd3};
        step();
        req_valid = 2'b00;
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 8'h11;
        step();
        cfg_we = 1'b0;
        repeat (4) step();
        got.delete();
        req_valid = 2'b01; req_start = {3'd0, 3'd2}; req_len_m1 = '0;
        step();
        req_valid = 2'b00;
        repeat (2) step();
        chk("t5_count", got.size(), 1);
        if (got.size() == 1) chk("t5_readback", got[0][7:0], 8'h55);

        // async reset in the middle of a burst
        req_valid = 2'b01; req_start = {3'd0, 3'd0}; req_len_m1 = {3'd0, 3'd7};
        step();
        req_valid = 2'b00;
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_out_last", out_last, 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        got.delete();
        req_valid = 2'b11; req_start = {3'd2, 3'd2}; req_len_m1 = '0;
        step();
        req_valid = 2'b00;
        repeat (2) step();
        chk("t6_count", got.size(), 1);
        if (got.size() == 1) begin
            chk("t6_data", got[0][7:0], 8'hE2);
            chk("t6_id", got[0][9], 0);
        end

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            req_valid  = 2'($urandom);
            req_start  = 6'($urandom);
            req_len_m1 = 6'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            cfg_we     = ($urandom_range(0, 4) == 0);
            cfg_addr   = 3'($urandom);
            cfg_wdata  = 8'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_playback_arbiter.md
Name: seq_playback_arbiter

Overview:
- Sequences and shares one 8-entry byte sequence table between NREQ requesters.
- Each requester asks for a burst: a start index and a length. The block plays the burst out on a single valid/ready stream, wrapping the index modulo DEPTH.
- The table is programmable through a config write port while the block is idle.
- Sits between the control requesters and the downstream byte consumer.

Parameters:
- DATA_W, 8, table entry and output width
- DEPTH, 8, table entries (power of two); IDX_W = clog2(DEPTH) = 3
- NREQ, 2, number of requesters (arbiter is built for 2; other values unsupported)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  IDX_W  table write address
- cfg_wdata  in  DATA_W  table write data
- cfg_ready  out  1  high when a write is accepted (= !busy)
- req_valid  in  NREQ  per-requester burst request
- req_ready  out  NREQ  per-requester grant/accept
- req_start  in  NREQ*IDX_W  per-requester start index, packed, requester 0 in LSBs
- req_len_m1  in  NREQ*IDX_W  per-requester burst length minus 1 (0..7 means 1..8 beats)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  table[idx]
- out_id  out  1  requester owning the current burst
- out_last  out  1  final beat of the burst
- busy  out  1  burst in progress

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE.
  - out_valid, out_last, busy, out_id and req_ready are 0; out_data is 0.
  - Round-robin pointer is 0.
  - Table reloads defaults: [0]=AF, [1]=BC, [2]=E2, [3]=78, [4]=FF, [5]=E2, [6]=0B, [7]=8D.
- FSM states: IDLE and PLAY.
- In IDLE, arbitration is combinational:
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to the requester selected by the round-robin pointer.
  - req_ready is high only for the granted requester; a request is accepted when its req_valid and req_ready are both high.
  - On accept:
    - latch idx = start, remain = len_m1 and out_id;
    - the pointer moves to the other requester;
    - the FSM goes to PLAY.
- Latency: accept at edge N gives out_valid = 1 and out_data = table[start] in the cycle after N.
- In PLAY:
  - out_valid = 1, out_data is registered as table[idx], and out_last = (remain == 0).
  - Outputs hold stable while out_ready = 0 (backpressure; no beat lost or repeated).
  - On out_valid & out_ready with remain != 0: idx = idx+1 (mod DEPTH, 7 wraps to 0), remain decrements.
  - On the last beat accepted: go to IDLE; out_valid, out_last and busy drop the next cycle. A new grant is possible in that IDLE cycle, so there is one bubble cycle between bursts.
- req_ready is 0 in PLAY. Requests are level-held by requesters until accepted; the block does not queue them.
- Config writes:
  - Applied at the clock edge when cfg_we & cfg_ready.
  - cfg_we while busy is ignored with no side effect.
  - A write and a request accept on the same IDLE edge: the write lands first in effect, so the burst reads the new value.
- busy = (state == PLAY).
- Reset mid-burst aborts the burst with no completion beat.
- Width rules: idx is IDX_W bits and wraps naturally; remain is IDX_W bits. A length of 8 beats (len_m1 = 7) starting at any index visits every entry once.

Decomposition:
- Shared package seq_pkg holds:
  - DATA_W, DEPTH, IDX_W constants;
  - the default-table constant array (AF, BC, E2, 78, FF, E2, 0B, 8D);
  - an FSM state enum {IDLE, PLAY}.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant with pointer update on accept).
- The table and the playback FSM stay in the top module.

Test Plan:
- Default playback: after reset, req0 start=0, len_m1=7, out_ready=1 -> 8 beats AF, BC, E2, 78, FF, E2, 0B, 8D, out_last on the 8th beat only, out_id=0, out_valid first high one cycle after accept.
- Wrap-around: req1 start=6, len_m1=3 -> beats 0B, 8D, AF, BC with out_id=1; busy drops the cycle after the last handshake.
- Backpressure: in the previous scenario, hold out_ready=0 for 3 cycles on beat 2 -> 8D held stable, and the total sequence is unchanged.
- Arbitration: both valid continuously with len_m1=0 -> grants alternate 0, 1, 0, 1 with one bubble between bursts. With only req1 valid -> req1 granted every time.
- Config: write addr 2 = 55 in IDLE, then burst start=1, len_m1=1 -> BC, 55. A write issued while busy is ignored (cfg_ready=0) and a later readback shows the old value.
- Async reset mid-burst at beat 3 -> out_valid/busy go to 0 immediately, the table returns to defaults (a written 55 becomes E2 again), and the pointer returns to 0.
